fresh_query_sched: RTL and testbench
====================================

// Module: fresh_query_sched
// PURPOSE
//  Sequences ingredient-ID queries into the read port of the fresh-ingredient bitmap (check_addr/out_fresh).
//  Only issues queries while the range loader reports check_ready, aligns each returned bit with its address,
//  and tallies fresh hits. Signals done after the query flagged last has retired. Sits between the query stream and the range/bitmap block.
// PARAMETERS
//  ADDR_W  17  ingredient address width; must match the bitmap block
//  CNT_W   17  width of hit counters
//  LAT     2   edges from check_addr change to fresh_in valid (BRAM read + out_fresh reg)
// PORTS
//  clk          in   1       single clock, shared with the bitmap block
//  rst          in   1       synchronous, active-low reset
//  start        in   1       pulse: clear counters, begin a query pass
//  q_valid      in   1       query available
//  q_addr       in   ADDR_W  ingredient ID to check
//  q_last       in   1       final query of the pass
//  q_ready      out  1       query accepted on edge when q_valid & q_ready
//  ram_ready    in   1       bitmap consistent (bitmap block check_ready)
//  check_addr   out  ADDR_W  read address to bitmap
//  fresh_in     in   1       bitmap result (bitmap block out_fresh)
//  res_valid    out  1       one-cycle result strobe
//  res_addr     out  ADDR_W  address of this result
//  res_fresh    out  1       1 = fresh
//  fresh_count  out  CNT_W   fresh results this pass
//  done         out  1       pass complete; held until start or reset
// BEHAVIOUR
//  Reset (rst==0 at an edge): state IDLE, all outputs 0, in-flight pipeline discarded; priority over every other input.
//  States:
//  - IDLE: q_ready=0; start -> RUN, counters cleared.
//  - RUN: q_ready = q_valid-independent ram_ready (combinational). Accept -> check_addr<=q_addr and a token {addr,last} is pushed into a LAT+1 stage valid/addr pipeline. Accept with q_last -> DRAIN.
//  - DRAIN: q_ready=0; when no token in flight and last result emitted -> DONE.
//  - DONE: done=1, q_ready=0; start -> RUN (counters cleared, done<=0 same edge).
//  start in RUN/DRAIN ignored.
//  Latency: accept on edge k -> res_valid=1 after edge k+LAT+1, for one cycle.
//  - Result fields: res_fresh = fresh_in sampled at that edge; res_addr = token addr.
//  Throughput: one query per cycle while ram_ready=1; back-to-back results in accept order.
//  check_addr holds its last value when nothing is accepted.
//  ram_ready falling mid-RUN: no new accepts; tokens already in flight still complete.
//  Counter: fresh_count += res_fresh with each res_valid; saturates at all-ones, no wrap.
//  q_last with q_ready=0 has no effect until accepted.
//  DONE asserts on the edge after the last res_valid cycle; res_valid and done never overlap.
// CONFIGURATION
//  FRESH_SCHED_SPOILED_CNT_EN defined: adds port spoiled_count (out, CNT_W).
//  - Increments on res_valid & !res_fresh; saturating; cleared by start and reset.
//  Undefined: port and logic absent; all other behaviour identical.
// TESTING
//  Reset hold: rst=0 for 3 cycles with q_valid=1 -> q_ready=0, res_valid=0, done=0, counts=0.
//  Basic pass: start; queries 5,6,7 (7 last), bitmap fresh at 5,7, ram_ready=1 -> results (5,1),(6,0),(7,1).
//  - Basic pass: first res_valid LAT+1 edges after accepting 5; fresh_count=2; done=1 one edge after result 7.
//  Stall: ram_ready=0 for 10 cycles after query 6 accepted -> q_ready=0 throughout, 6 still retires on time, 7 accepted when ram_ready=1.
//  Saturation: CNT_W=2, 5 fresh queries -> fresh_count sticks at 3.
//  Restart/abort: start in DONE -> count=0 and new pass works; rst=0 mid-DRAIN -> no further res_valid, state IDLE.
//  Option: FRESH_SCHED_SPOILED_CNT_EN build of the basic pass -> spoiled_count=1.

Source files
------------

// File: rtl/fresh_query_sched.sv
// Query sequencer for the fresh-ingredient bitmap read port: aligns each returned bit with its address and tallies hits.
// Optional FRESH_SCHED_SPOILED_CNT_EN adds a saturating spoiled_count output.
module fresh_query_sched #(
  parameter int ADDR_W = 17,
  parameter int CNT_W  = 17,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              q_valid,
  input  logic [ADDR_W-1:0] q_addr,
  input  logic              q_last,
  output logic              q_ready,
  input  logic              ram_ready,
  output logic [ADDR_W-1:0] check_addr,
  input  logic              fresh_in,
  output logic              res_valid,
  output logic [ADDR_W-1:0] res_addr,
  output logic              res_fresh,
  output logic [CNT_W-1:0]  fresh_count,
`ifdef FRESH_SCHED_SPOILED_CNT_EN
  output logic [CNT_W-1:0]  spoiled_count,
`endif
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                   state;
  logic [LAT:0]             vld_pipe;
  logic [LAT:0]             last_pipe;
  logic [LAT:0][ADDR_W-1:0] addr_pipe;
  logic                     res_last;
  logic                     accept;

  assign q_ready = (state == RUN) && ram_ready;
  assign accept  = q_valid && q_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      check_addr  <= '0;
      vld_pipe    <= '0;
      last_pipe   <= '0;
      addr_pipe   <= '0;
      res_valid   <= 1'b0;
      res_addr    <= '0;
      res_fresh   <= 1'b0;
      res_last    <= 1'b0;
      fresh_count <= '0;
`ifdef FRESH_SCHED_SPOILED_CNT_EN
      spoiled_count <= '0;
`endif
      done        <= 1'b0;
    end else begin
      // Token stage LAT lines up with fresh_in for the address issued LAT+1 edges earlier.
      for (int i = LAT; i > 0; i--) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
      vld_pipe[0]  <= accept;
      last_pipe[0] <= q_last;
      addr_pipe[0] <= q_addr;
      if (accept) check_addr <= q_addr;

      res_valid <= vld_pipe[LAT];
      if (vld_pipe[LAT]) begin
        res_addr  <= addr_pipe[LAT];
        res_fresh <= fresh_in;
        res_last  <= last_pipe[LAT];
        if (fresh_in && fresh_count != CNT_MAX) fresh_count <= fresh_count + 1'b1;
`ifdef FRESH_SCHED_SPOILED_CNT_EN
        if (!fresh_in && spoiled_count != CNT_MAX) spoiled_count <= spoiled_count + 1'b1;
`endif
      end

      case (state)
        IDLE, DONE: if (start) begin
          state       <= RUN;
          done        <= 1'b0;
          fresh_count <= '0;
`ifdef FRESH_SCHED_SPOILED_CNT_EN
          spoiled_count <= '0;
`endif
        end
        RUN: if (accept && q_last) state <= DRAIN;
        DRAIN: if (vld_pipe == '0 && res_valid && res_last) begin
          state <= DONE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fresh_query_sched.sv
// Directed bench for fresh_query_sched: reset, basic pass, stall, saturation, restart and abort.
// Define FRESH_SCHED_SPOILED_CNT_EN to also check spoiled_count.
module tb_fresh_query_sched;
  localparam int ADDR_W = 17;
  localparam int CNT_W  = 17;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, q_valid = 1'b0, q_last = 1'b0, ram_ready = 1'b0;
  logic fresh_in, rd1;
  logic [ADDR_W-1:0] q_addr = '0;
  logic q_ready, res_valid, res_fresh, done;
  logic [ADDR_W-1:0] check_addr, res_addr;
  logic [CNT_W-1:0] fresh_count;
  logic sq_ready, sres_valid, sres_fresh, sdone;
  logic [ADDR_W-1:0] scheck_addr, sres_addr;
  logic [1:0] sfresh_count;
`ifdef FRESH_SCHED_SPOILED_CNT_EN
  logic [CNT_W-1:0] spoiled_count;
  logic [1:0] sspoiled_count;
`endif
  logic [255:0] bitmap;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  // Two-edge bitmap read: BRAM register then out_fresh register.
  always @(posedge clk) begin
    rd1      <= bitmap[check_addr[7:0]];
    fresh_in <= rd1;
  end

  fresh_query_sched #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .q_valid(q_valid), .q_addr(q_addr), .q_last(q_last),
    .q_ready(q_ready), .ram_ready(ram_ready), .check_addr(check_addr), .fresh_in(fresh_in),
    .res_valid(res_valid), .res_addr(res_addr), .res_fresh(res_fresh), .fresh_count(fresh_count),
`ifdef FRESH_SCHED_SPOILED_CNT_EN
    .spoiled_count(spoiled_count),
`endif
    .done(done));

  fresh_query_sched #(.ADDR_W(ADDR_W), .CNT_W(2), .LAT(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .q_valid(q_valid), .q_addr(q_addr), .q_last(q_last),
    .q_ready(sq_ready), .ram_ready(ram_ready), .check_addr(scheck_addr), .fresh_in(fresh_in),
    .res_valid(sres_valid), .res_addr(sres_addr), .res_fresh(sres_fresh), .fresh_count(sfresh_count),
`ifdef FRESH_SCHED_SPOILED_CNT_EN
    .spoiled_count(sspoiled_count),
`endif
    .done(sdone));

  task automatic test_reset();
    rst = 1'b0; q_valid = 1'b1; ram_ready = 1'b1; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (q_ready !== 1'b0) begin errors++; $display("FAIL reset_q_ready got %0b want 0", q_ready); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %0b want 0", res_valid); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
      checks++; if (fresh_count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", fresh_count); end
    end
    rst = 1'b1; q_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [ADDR_W-1:0] ea [3];
    logic ef [3];
    ea[0] = 5; ea[1] = 6; ea[2] = 7; ef[0] = 1'b1; ef[1] = 1'b0; ef[2] = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0; q_valid = 1'b1; q_addr = 5; ram_ready = 1'b1;
    #1;
    checks++; if (q_ready !== 1'b1) begin errors++; $display("FAIL basic_q_ready got %0b want 1", q_ready); end
    @(negedge clk) q_addr = 6;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_early1 got %0b want 0", res_valid); end
    @(negedge clk) q_addr = 7; q_last = 1'b1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_early2 got %0b want 0", res_valid); end
    @(negedge clk) q_valid = 1'b0; q_last = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_early3 got %0b want 0", res_valid); end
    #1;
    checks++; if (q_ready !== 1'b0) begin errors++; $display("FAIL basic_drain_q_ready got %0b want 0", q_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL basic_res_valid[%0d] got %0b want 1", i, res_valid); end
      checks++; if (res_addr !== ea[i]) begin errors++; $display("FAIL basic_res_addr[%0d] got %0d want %0d", i, res_addr, ea[i]); end
      checks++; if (res_fresh !== ef[i]) begin errors++; $display("FAIL basic_res_fresh[%0d] got %0b want %0b", i, res_fresh, ef[i]); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_early[%0d] got %0b want 0", i, done); end
    end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got %0b want 1", done); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_res_after got %0b want 0", res_valid); end
    checks++; if (fresh_count !== 17'd2) begin errors++; $display("FAIL basic_count got %0d want 2", fresh_count); end
`ifdef FRESH_SCHED_SPOILED_CNT_EN
    checks++; if (spoiled_count !== 17'd1) begin errors++; $display("FAIL basic_spoiled got %0d want 1", spoiled_count); end
`endif
  endtask

  task automatic test_stall();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++; if (fresh_count !== '0) begin errors++; $display("FAIL restart_count got %0d want 0", fresh_count); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL restart_done got %0b want 0", done); end
    q_valid = 1'b1; q_addr = 5; ram_ready = 1'b1;
    @(negedge clk) q_addr = 6;
    @(negedge clk) q_addr = 7; q_last = 1'b1; ram_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++; if (q_ready !== 1'b0) begin errors++; $display("FAIL stall_q_ready[%0d] got %0b want 0", i, q_ready); end
      checks++; if (res_valid !== (i == 2 || i == 3)) begin errors++; $display("FAIL stall_res_valid[%0d] got %0b", i, res_valid); end
      if (i == 2) begin
        checks++; if (res_addr !== 17'd5) begin errors++; $display("FAIL stall_addr5 got %0d want 5", res_addr); end
      end
      if (i == 3) begin
        checks++; if (res_addr !== 17'd6 || res_fresh !== 1'b0) begin errors++; $display("FAIL stall_res6 got %0d/%0b want 6/0", res_addr, res_fresh); end
      end
    end
    ram_ready = 1'b1;
    #1;
    checks++; if (q_ready !== 1'b1) begin errors++; $display("FAIL stall_resume got %0b want 1", q_ready); end
    @(negedge clk) q_valid = 1'b0; q_last = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL stall_gap[%0d] got %0b want 0", i, res_valid); end
    end
    @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_addr !== 17'd7 || res_fresh !== 1'b1) begin errors++; $display("FAIL stall_res7 got %0b/%0d/%0b want 1/7/1", res_valid, res_addr, res_fresh); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done got %0b want 1", done); end
    checks++; if (fresh_count !== 17'd2) begin errors++; $display("FAIL stall_count got %0d want 2", fresh_count); end
  endtask

  task automatic test_saturation();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0; q_valid = 1'b1; ram_ready = 1'b1;
    // start pulse on the third query lands in RUN and must be ignored
    for (int i = 0; i < 5; i++) begin
      q_addr = (i % 2 == 1) ? 17'd7 : 17'd5; q_last = (i == 4); start = (i == 2);
      @(negedge clk);
    end
    q_valid = 1'b0; q_last = 1'b0; start = 1'b0;
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sat_done_timeout got %0b want 1", done); end
    checks++; if (fresh_count !== 17'd5) begin errors++; $display("FAIL sat_wide_count got %0d want 5", fresh_count); end
    checks++; if (sfresh_count !== 2'd3) begin errors++; $display("FAIL sat_count got %0d want 3", sfresh_count); end
    checks++; if (sdone !== 1'b1) begin errors++; $display("FAIL sat_done got %0b want 1", sdone); end
  endtask

  task automatic test_abort();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0; q_valid = 1'b1; q_addr = 5; ram_ready = 1'b1;
    @(negedge clk) q_addr = 6;
    @(negedge clk) q_addr = 7; q_last = 1'b1;
    @(negedge clk) q_valid = 1'b0; q_last = 1'b0; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL abort_res_valid[%0d] got %0b want 0", i, res_valid); end
      checks++; if (done !== 1'b0 || fresh_count !== '0) begin errors++; $display("FAIL abort_state[%0d] got done=%0b cnt=%0d want 0/0", i, done, fresh_count); end
    end
    rst = 1'b1; q_valid = 1'b1;
    #1;
    checks++; if (q_ready !== 1'b0) begin errors++; $display("FAIL abort_idle_q_ready got %0b want 0", q_ready); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL abort_idle_res[%0d] got %0b want 0", i, res_valid); end
    end
    q_valid = 1'b0;
  endtask

  initial begin
    bitmap = '0; bitmap[5] = 1'b1; bitmap[7] = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_saturation();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
